// File: rtl/inst_status_gen_if.sv
// Controller <-> status-generator link: the instruction word going out and the status flags coming back.
interface inst_status_gen_if;
    logic [18:0] inst;
    logic        q_full;
    logic        k_full;
    logic        ld_done;
    logic        ofifo_wr;
    logic        ofifo_full;
    logic        sfp_ready;
    logic        int_fifo_full;

    modport master (
        output inst,
        input  q_full, k_full, ld_done, ofifo_wr, ofifo_full, sfp_ready, int_fifo_full
    );

    modport slave (
        input  inst,
        output q_full, k_full, ld_done, ofifo_wr, ofifo_full, sfp_ready, int_fifo_full
    );
endinterface

// File: rtl/inst_status_gen.sv
// Datapath-side responder: decodes instruction strobes, tracks buffer/FIFO/SFP state
// and returns registered status flags to the controller.
module inst_status_gen #(
    parameter int unsigned Q_DEPTH     = 8,
    parameter int unsigned K_DEPTH     = 8,
    parameter int unsigned LD_LEN      = 8,
    parameter int unsigned OFIFO_DEPTH = 8,
    parameter int unsigned INT_DEPTH   = 4,
    parameter int unsigned SFP_LAT     = 5
) (
    input  logic               clk,
    input  logic               reset,
    inst_status_gen_if.slave   bus
);
    localparam int unsigned QW = $clog2(Q_DEPTH + 1);
    localparam int unsigned KW = $clog2(K_DEPTH + 1);
    localparam int unsigned LW = $clog2(LD_LEN + 1);
    localparam int unsigned OW = $clog2(OFIFO_DEPTH + 1);
    localparam int unsigned IW = $clog2(INT_DEPTH + 1);
    localparam int unsigned TW = (SFP_LAT > 1) ? $clog2(SFP_LAT) : 1;

    typedef enum logic [1:0] {
        SFP_IDLE  = 2'd0,
        SFP_BUSY  = 2'd1,
        SFP_READY = 2'd2
    } sfp_state_t;

    logic [18:0] w_inst;
    logic        w_act, w_clr;
    logic        w_k_wr, w_ld, w_q_wr;
    logic        w_of_push, w_of_pop, w_int_push, w_int_pop;
    logic        w_sfp_start, w_sfp_ack;
    logic        w_unused_bits;

    assign w_inst        = bus.inst;
    assign w_act         = w_inst[14] & w_inst[13] & w_inst[12];
    assign w_clr         = w_inst[11];
    assign w_k_wr        = w_act & w_inst[2];
    assign w_ld          = w_act & w_inst[3];
    assign w_q_wr        = w_act & w_inst[4];
    assign w_of_push     = w_act & w_inst[5] & w_inst[7];
    assign w_of_pop      = w_act & w_inst[6];
    assign w_sfp_start   = w_act & w_inst[8];
    assign w_sfp_ack     = w_act & w_inst[9];
    assign w_int_push    = w_act & w_inst[10];
    assign w_int_pop     = w_act & w_inst[15];
    assign w_unused_bits = ^{w_inst[18:16], w_inst[1:0]};

    logic [QW-1:0] r_q_cnt,   w_q_nxt;
    logic [KW-1:0] r_k_cnt,   w_k_nxt;
    logic [LW-1:0] r_ld_cnt,  w_ld_nxt;
    logic [OW-1:0] r_of_cnt,  w_of_nxt;
    logic [IW-1:0] r_int_cnt, w_int_nxt;
    logic          w_of_push_acc, w_of_pop_acc, w_int_push_acc, w_int_pop_acc;

    // Saturating fill counters; clear has priority over any write strobe
    always_comb begin
        w_q_nxt  = r_q_cnt;
        w_k_nxt  = r_k_cnt;
        w_ld_nxt = r_ld_cnt;
        if (w_clr) begin
            w_q_nxt  = '0;
            w_k_nxt  = '0;
            w_ld_nxt = '0;
        end else begin
            if (w_q_wr && (r_q_cnt != QW'(Q_DEPTH)))  w_q_nxt  = r_q_cnt + QW'(1);
            if (w_k_wr && (r_k_cnt != KW'(K_DEPTH)))  w_k_nxt  = r_k_cnt + KW'(1);
            if (w_ld   && (r_ld_cnt != LW'(LD_LEN)))  w_ld_nxt = r_ld_cnt + LW'(1);
        end
    end

    // A push into a full FIFO is still accepted when a pop frees the slot in the same cycle
    assign w_of_push_acc  = w_of_push  & ((r_of_cnt != OW'(OFIFO_DEPTH)) | w_of_pop);
    assign w_of_pop_acc   = w_of_pop   & (r_of_cnt != '0);
    assign w_int_push_acc = w_int_push & ((r_int_cnt != IW'(INT_DEPTH)) | w_int_pop);
    assign w_int_pop_acc  = w_int_pop  & (r_int_cnt != '0);

    always_comb begin
        w_of_nxt  = r_of_cnt;
        w_int_nxt = r_int_cnt;
        case ({w_of_push_acc, w_of_pop_acc})
            2'b10:   w_of_nxt = r_of_cnt + OW'(1);
            2'b01:   w_of_nxt = r_of_cnt - OW'(1);
            default: w_of_nxt = r_of_cnt;
        endcase
        case ({w_int_push_acc, w_int_pop_acc})
            2'b10:   w_int_nxt = r_int_cnt + IW'(1);
            2'b01:   w_int_nxt = r_int_cnt - IW'(1);
            default: w_int_nxt = r_int_cnt;
        endcase
    end

    logic r_q_full, r_k_full, r_ld_done, r_ofifo_wr, r_ofifo_full, r_int_fifo_full;

    // Counters and their flags update together so every flag comes straight from a flop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q_cnt         <= '0;
            r_k_cnt         <= '0;
            r_ld_cnt        <= '0;
            r_of_cnt        <= '0;
            r_int_cnt       <= '0;
            r_q_full        <= 1'b0;
            r_k_full        <= 1'b0;
            r_ld_done       <= 1'b0;
            r_ofifo_wr      <= 1'b0;
            r_ofifo_full    <= 1'b0;
            r_int_fifo_full <= 1'b0;
        end else begin
            r_q_cnt         <= w_q_nxt;
            r_k_cnt         <= w_k_nxt;
            r_ld_cnt        <= w_ld_nxt;
            r_of_cnt        <= w_of_nxt;
            r_int_cnt       <= w_int_nxt;
            r_q_full        <= (w_q_nxt == QW'(Q_DEPTH));
            r_k_full        <= (w_k_nxt == KW'(K_DEPTH));
            r_ld_done       <= (w_ld_nxt == LW'(LD_LEN));
            r_ofifo_wr      <= w_of_push_acc;
            r_ofifo_full    <= (w_of_nxt == OW'(OFIFO_DEPTH));
            r_int_fifo_full <= (w_int_nxt == IW'(INT_DEPTH));
        end
    end

    sfp_state_t    r_sfp_state;
    logic [TW-1:0] r_sfp_timer;
    logic          r_sfp_ready;

    // SFP latency tracker; the timer runs freely once started, clear aborts to IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sfp_state <= SFP_IDLE;
            r_sfp_timer <= '0;
            r_sfp_ready <= 1'b0;
        end else if (w_clr) begin
            r_sfp_state <= SFP_IDLE;
            r_sfp_timer <= '0;
            r_sfp_ready <= 1'b0;
        end else begin
            case (r_sfp_state)
                SFP_IDLE: begin
                    if (w_sfp_start) begin
                        r_sfp_state <= SFP_BUSY;
                        r_sfp_timer <= TW'(SFP_LAT - 1);
                    end
                end
                SFP_BUSY: begin
                    if (r_sfp_timer == '0) begin
                        r_sfp_state <= SFP_READY;
                        r_sfp_ready <= 1'b1;
                    end else begin
                        r_sfp_timer <= r_sfp_timer - TW'(1);
                    end
                end
                SFP_READY: begin
                    if (w_sfp_ack) begin
                        r_sfp_state <= SFP_IDLE;
                        r_sfp_ready <= 1'b0;
                    end
                end
                default: begin
                    r_sfp_state <= SFP_IDLE;
                    r_sfp_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q_full        = r_q_full;
    assign bus.k_full        = r_k_full;
    assign bus.ld_done       = r_ld_done;
    assign bus.ofifo_wr      = r_ofifo_wr;
    assign bus.ofifo_full    = r_ofifo_full;
    assign bus.sfp_ready     = r_sfp_ready;
    assign bus.int_fifo_full = r_int_fifo_full;

endmodule

// File: tb/tb_inst_status_gen.sv
// Bench for inst_status_gen: directed boundary scenarios followed by random instruction
// words, all compared against a queue/edge-count reference model.
module tb_inst_status_gen;
    localparam int unsigned QD  = 8;
    localparam int unsigned KD  = 8;
    localparam int unsigned LDL = 8;
    localparam int unsigned OD  = 8;
    localparam int unsigned ID  = 4;
    localparam int unsigned SL  = 5;

    localparam logic [18:0] ACT      = 19'h07000;
    localparam logic [18:0] K_WR     = 19'h00004;
    localparam logic [18:0] LD       = 19'h00008;
    localparam logic [18:0] Q_WR     = 19'h00010;
    localparam logic [18:0] OF_PUSH  = 19'h000A0;
    localparam logic [18:0] OF_POP   = 19'h00040;
    localparam logic [18:0] SFP_ST   = 19'h00100;
    localparam logic [18:0] SFP_ACK  = 19'h00200;
    localparam logic [18:0] INT_PUSH = 19'h00400;
    localparam logic [18:0] CLR      = 19'h00800;
    localparam logic [18:0] INT_POP  = 19'h08000;
    localparam logic [18:0] IGN      = 19'h70003;

    logic clk = 1'b0;
    logic reset;

    inst_status_gen_if bus();

    inst_status_gen #(
        .Q_DEPTH(QD), .K_DEPTH(KD), .LD_LEN(LDL),
        .OFIFO_DEPTH(OD), .INT_DEPTH(ID), .SFP_LAT(SL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain counts, FIFOs as queues, SFP as "edges since start"
    int m_q, m_k, m_ld;
    int m_ofq[$];
    int m_intq[$];
    bit m_wr;
    int m_phase;      // 0 idle, 1 waiting for latency, 2 result ready
    int m_edge;
    int m_start_edge;
    int m_tag;

    function void m_reset();
        m_q = 0; m_k = 0; m_ld = 0;
        m_ofq.delete();
        m_intq.delete();
        m_wr = 1'b0;
        m_phase = 0;
        m_start_edge = 0;
    endfunction

    function void m_apply(input logic [18:0] x);
        bit act;
        bit clr;
        act = &x[14:12];
        clr = x[11];
        m_edge++;
        if (clr) begin
            m_q = 0; m_k = 0; m_ld = 0;
        end else begin
            if (act && x[4] && m_q  < int'(QD))  m_q++;
            if (act && x[2] && m_k  < int'(KD))  m_k++;
            if (act && x[3] && m_ld < int'(LDL)) m_ld++;
        end
        // pop first so a push into a full FIFO fits when a pop happens alongside
        m_wr = 1'b0;
        if (act && x[6] && m_ofq.size() > 0) void'(m_ofq.pop_front());
        if (act && x[5] && x[7] && m_ofq.size() < int'(OD)) begin
            m_ofq.push_back(m_tag++);
            m_wr = 1'b1;
        end
        if (act && x[15] && m_intq.size() > 0) void'(m_intq.pop_front());
        if (act && x[10] && m_intq.size() < int'(ID)) m_intq.push_back(m_tag++);
        if (clr) m_phase = 0;
        else begin
            case (m_phase)
                0: if (act && x[8]) begin m_phase = 1; m_start_edge = m_edge; end
                1: if (m_edge - m_start_edge >= int'(SL)) m_phase = 2;
                2: if (act && x[9]) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    endfunction

    task automatic check_all();
        chk("q_full",        32'(bus.q_full),        32'(m_q == int'(QD)));
        chk("k_full",        32'(bus.k_full),        32'(m_k == int'(KD)));
        chk("ld_done",       32'(bus.ld_done),       32'(m_ld == int'(LDL)));
        chk("ofifo_wr",      32'(bus.ofifo_wr),      32'(m_wr));
        chk("ofifo_full",    32'(bus.ofifo_full),    32'(m_ofq.size() == int'(OD)));
        chk("sfp_ready",     32'(bus.sfp_ready),     32'(m_phase == 2));
        chk("int_fifo_full", 32'(bus.int_fifo_full), 32'(m_intq.size() == int'(ID)));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_flags"}, 32'({bus.q_full, bus.k_full, bus.ld_done, bus.ofifo_wr,
                                  bus.ofifo_full, bus.sfp_ready, bus.int_fifo_full}), 32'd0);
    endtask

    task automatic step(input logic [18:0] x);
        bus.inst = x;
        @(posedge clk);
        m_apply(x);
        #1;
        check_all();
    endtask

    int pulses;
    logic [18:0] rx;

    initial begin
        m_edge = 0;
        m_tag  = 0;
        m_reset();
        reset    = 1'b0;
        bus.inst = '0;
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset_state");
        reset = 1'b1;

        // idle cycles keep everything low
        repeat (10) step('0);
        check_zero("idle");

        // q fill, saturation, clear
        for (int i = 0; i < 8; i++) step(ACT | Q_WR);
        chk("q_full_8th", 32'(bus.q_full), 32'd1);
        step(ACT | Q_WR);
        chk("q_full_9th", 32'(bus.q_full), 32'd1);
        step(CLR);
        chk("q_full_clr", 32'(bus.q_full), 32'd0);

        // k and load, with ignored bits set
        for (int i = 0; i < 9; i++) step(ACT | K_WR | LD | IGN);
        chk("k_full_sat", 32'(bus.k_full), 32'd1);
        chk("ld_done_sat", 32'(bus.ld_done), 32'd1);
        step(ACT | CLR | K_WR | LD | OF_PUSH);

        // output FIFO boundaries (one entry from the clear step above)
        for (int i = 0; i < 12; i++) step(ACT | OF_POP);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(ACT | OF_PUSH);
            pulses += int'(bus.ofifo_wr);
        end
        chk("wr_pulses", 32'(pulses), 32'd8);
        chk("ofifo_full_8", 32'(bus.ofifo_full), 32'd1);
        step(ACT | OF_PUSH);
        chk("wr_9th_push", 32'(bus.ofifo_wr), 32'd0);
        step(ACT | OF_PUSH | OF_POP);
        chk("full_pushpop", 32'(bus.ofifo_full), 32'd1);
        for (int i = 0; i < 9; i++) step(ACT | OF_POP);
        step(ACT | OF_PUSH | OF_POP);
        chk("empty_pushpop_wr", 32'(bus.ofifo_wr), 32'd1);
        for (int i = 0; i < 7; i++) step(ACT | OF_PUSH);
        chk("occ_after_empty_pop", 32'(bus.ofifo_full), 32'd1);
        for (int i = 0; i < 8; i++) step(ACT | OF_POP);

        // intermediate FIFO
        for (int i = 0; i < 5; i++) step(ACT | INT_PUSH);
        chk("int_full", 32'(bus.int_fifo_full), 32'd1);
        step(ACT | INT_PUSH | INT_POP);
        for (int i = 0; i < 6; i++) step(ACT | INT_POP);

        // SFP latency: start edge 0, ignored restart edge 2, ack edge 8
        step(ACT | SFP_ST);
        step('0);
        step(ACT | SFP_ST);
        step(ACT | SFP_ACK);
        step('0);
        chk("sfp_before", 32'(bus.sfp_ready), 32'd0);
        step('0);
        chk("sfp_edge5", 32'(bus.sfp_ready), 32'd1);
        step(ACT | SFP_ST);
        step('0);
        step(ACT | SFP_ACK);
        chk("sfp_ack", 32'(bus.sfp_ready), 32'd0);

        // gating: act=110 must not count, ungated clear still clears
        for (int i = 0; i < 10; i++) step(19'h06000 | Q_WR | K_WR);
        for (int i = 0; i < 7; i++) step(ACT | Q_WR | K_WR);
        chk("gated_q", 32'(bus.q_full), 32'd0);
        step(19'h06000 | CLR);
        for (int i = 0; i < 7; i++) step(ACT | Q_WR | K_WR);
        chk("clr_gated_q", 32'(bus.q_full), 32'd0);
        step(ACT | Q_WR | K_WR);
        chk("refill_q", 32'(bus.q_full), 32'd1);

        // async reset while BUSY with three entries in the output FIFO
        for (int i = 0; i < 3; i++) step(ACT | OF_PUSH);
        step(ACT | SFP_ST);
        step('0);
        #3;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        m_reset();
        check_all();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 7; i++) step(ACT | OF_PUSH);
        chk("occ_post_reset_7", 32'(bus.ofifo_full), 32'd0);
        step(ACT | OF_PUSH);
        chk("occ_post_reset_8", 32'(bus.ofifo_full), 32'd1);

        // random instruction words
        for (int i = 0; i < 3000; i++) begin
            rx = 19'($urandom);
            if ($urandom_range(9) < 7) rx[14:12] = 3'b111;
            rx[11] = ($urandom_range(31) == 0);
            step(rx);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/inst_status_gen.md
# inst_status_gen

Datapath-side responder for the 19-bit instruction word issued by `controller`. It decodes the per-cycle strobes in `inst` and tracks the resulting resource state: query-buffer fill, key-buffer fill, load progress, output-FIFO occupancy, SFP completion and intermediate-FIFO occupancy. It returns the status flags (`q_full`, `k_full`, `ld_done`, `ofifo_wr`, `ofifo_full`, `sfp_ready`, `int_fifo_full`) that `controller` consumes. It replaces the behavioural flag loopback with cycle-accurate, parameterised bookkeeping.

## Interface
- `Q_DEPTH`, default 8: q-buffer writes needed to assert `q_full`.
- `K_DEPTH`, default 8: k-buffer writes needed to assert `k_full`.
- `LD_LEN`, default 8: load strobes needed to assert `ld_done`.
- `OFIFO_DEPTH`, default 8: output-FIFO capacity in entries.
- `INT_DEPTH`, default 4: intermediate-FIFO capacity in entries.
- `SFP_LAT`, default 5: cycles from SFP start to `sfp_ready`; must be at least 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `inst` in 19: instruction word from `controller`.
- `q_full` out 1: q-buffer fill count equals `Q_DEPTH`.
- `k_full` out 1: k-buffer fill count equals `K_DEPTH`.
- `ld_done` out 1: load count equals `LD_LEN`; level signal.
- `ofifo_wr` out 1: one-cycle pulse; an output-FIFO push was accepted on the previous edge.
- `ofifo_full` out 1: output-FIFO occupancy equals `OFIFO_DEPTH`.
- `sfp_ready` out 1: SFP result available.
- `int_fifo_full` out 1: intermediate-FIFO occupancy equals `INT_DEPTH`.

## Operation
- Gate: `act` = `inst[14] & inst[13] & inst[12]`. Every strobe below except clear is qualified by `act`.
- Strobes:
  - `inst[2]`: k write.
  - `inst[3]`: load.
  - `inst[4]`: q write.
  - `inst[5] & inst[7]`: ofifo push.
  - `inst[6]`: ofifo pop.
  - `inst[8]`: SFP start.
  - `inst[9]`: SFP acknowledge.
  - `inst[10]`: int push.
  - `inst[15]`: int pop.
  - `inst[11]`: clear, which is **not** gated by `act`.
  - `inst[18:16]` and `inst[1:0]` are ignored.
- Counter widths are `$clog2(DEPTH+1)`. Counters saturate and never wrap. A write when full or a pop when empty is dropped silently, with no state change.
- q/k/ld counters: increment on their strobe while below the limit. Clear zeroes all three.
- Output FIFO:
  - push only: +1 if not full.
  - pop only: −1 if not empty.
  - push and pop together: occupancy unchanged when not empty. When empty, the push is accepted and the pop is dropped, so occupancy becomes 1.
  - Clear does not touch output-FIFO occupancy.
- Intermediate FIFO: same rules as the output FIFO, using `inst[10]`/`inst[15]` and `INT_DEPTH`. Clear does not touch it either.
- SFP FSM:
  - IDLE: on start, load timer with `SFP_LAT-1` and go to BUSY.
  - BUSY: decrement the timer each cycle; when it reaches 0, go to READY.
  - READY: on ack, go to IDLE.
  - Start while BUSY or READY is ignored. Ack outside READY is ignored. Clear forces IDLE from any state.
- Outputs: `sfp_ready` = (state == READY). `ofifo_wr` is registered: 1 for exactly one cycle after each accepted push.
- All outputs are decoded from flops only; there is no combinational path from `inst` to any output.

## Timing
- Reset: all counters 0, FSM IDLE, every output 0. Assertion mid-operation takes effect immediately (asynchronous). Operation resumes on the first edge after deassertion.
- Flag latency: a strobe sampled at edge *n* updates its counter at edge *n*. The corresponding flag is valid after edge *n*, i.e. one cycle of latency as seen by the controller's next edge.
- `ofifo_wr`: high in the cycle after edge *n* when the push was accepted at edge *n*.
- `sfp_ready`: rises exactly `SFP_LAT` edges after the start edge. It stays high until the ack edge and is low after that edge.
- Clear together with another strobe in the same cycle: clear wins for the q/k/ld counters and the FSM. FIFO strobes still apply.
- `act` = 0: only clear has effect; all other state holds.

## Test plan
- Reset then idle: `reset` low mid-cycle → all outputs 0 immediately. Release, drive `inst` = 0 for 10 cycles → all outputs remain 0.
- Fill q with `Q_DEPTH` = 8: 8 cycles of `act` + `inst[4]` → `q_full` = 1 after the 8th edge. A 9th strobe keeps count 8. Clear → `q_full` = 0 next cycle.
- Output-FIFO boundaries with depth 8:
  - 8 pushes → `ofifo_full` = 1, and 8 `ofifo_wr` pulses.
  - 9th push → no `ofifo_wr` pulse.
  - Simultaneous push+pop at full → stays full.
  - Pop on empty → occupancy stays 0.
- SFP with `SFP_LAT` = 5:
  - Start at edge 0 → `sfp_ready` = 1 after edge 5.
  - Second start at edge 2 → no effect.
  - Ack at edge 8 → 0 after edge 8.
- Gating: `inst[4]` and `inst[2]` with `inst[14:12]` = 3'b110 for 10 cycles → counts stay 0. Clear with `act` = 0 → still clears.
- `reset` asserted while in BUSY with ofifo occupancy 3 → FSM IDLE and all flags 0 immediately. Occupancy 0 after release.
